debounce_multi: RTL
===================

# debounce_multi

Parametrised multi-channel debouncer for push-button and switch inputs. Each channel synchronises an asynchronous input, samples it on the shared `load` tick from the pulse generator, and filters it through a DEPTH-deep history with hysteresis. Each channel outputs a debounced level, one-cycle rise and fall pulses, and a long-press indication. It sits between the board pins and the segment-load and counter logic, and replaces the single-channel debouncer.

## Interface
- `CHANNELS`, 5: number of independent inputs.
- `DEPTH`, 10: number of consecutive equal samples required to change the debounced level (minimum 2).
- `SYNC_STAGES`, 2: synchroniser flops per channel (minimum 2).
- `HOLD_TICKS`, 500: `load` ticks with `db` high before `hold` asserts (minimum 1).

- `clk`  in  1  system clock; all state is on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `load`  in  1  sample-enable tick, one `clk` wide; may be high every cycle.
- `button`  in  CHANNELS  raw asynchronous inputs.
- `db`  out  CHANNELS  debounced levels.
- `rise`  out  CHANNELS  one-cycle pulse when `db[i]` goes 0→1.
- `fall`  out  CHANNELS  one-cycle pulse when `db[i]` goes 1→0.
- `hold`  out  CHANNELS  level; high while `db[i]` has been high for at least HOLD_TICKS ticks.
- `hold_pulse`  out  CHANNELS  one-cycle pulse on the cycle `hold[i]` first asserts.

## Operation
- Synchroniser: a SYNC_STAGES-flop chain clocked every `clk` regardless of `load`. Its last stage is `s[i]`.
- History: DEPTH-bit shift register `h[i]`. On a cycle with `load`=1, `h` shifts to `{h[DEPTH-2:0], s[i]}`. With `load`=0, `h` holds.
- Hysteresis: `hn` is the history after the shift on a `load` cycle.
  - If `hn` is all ones, `db` becomes 1.
  - If `hn` is all zeros, `db` becomes 0.
  - Otherwise `db` holds. Bouncing alone never toggles `db`.
- Edge pulses: `rise` and `fall` are registered together with `db`. Each is high only in the first cycle that the new `db` value is visible. `rise` and `fall` are never high together.
- Hold counter: `cnt[i]` has width `$clog2(HOLD_TICKS+1)`.
  - It clears to 0 whenever `db[i]`=0.
  - While `db[i]`=1, it increments on each `load` cycle and saturates at HOLD_TICKS.
  - `hold[i]` = (`cnt[i]` == HOLD_TICKS).
  - `hold_pulse[i]` is high for exactly one cycle, in the first cycle that `hold[i]` is high.
- The tick that sets `db` does not count toward the hold. Counting starts on the next `load`.
- Channels are fully independent and share only `load`.

## Timing
- Reset (`rst`=0) acts immediately. The following all clear to 0: synchroniser flops, `h`, `db`, `rise`, `fall`, `cnt`, `hold`, `hold_pulse`.
- Leaving reset produces no pulses. After a mid-operation reset, a held button must requalify over DEPTH new samples.
- Worst-case latency with `load` high every cycle and the input stable: `db` changes SYNC_STAGES+DEPTH cycles after the input edge. With a tick every P cycles it is at most SYNC_STAGES+DEPTH·P cycles.
- `hold` asserts exactly HOLD_TICKS `load` ticks after the tick that set `db`.
- When `db` falls, `hold` deasserts in the same cycle that `fall` pulses.
- A `load` coinciding with `hn` qualifying is a normal update. No separate ordering case exists.

## Structure
- Shared package `debounce_pkg` holds:
  - default parameter values;
  - localparam function `cnt_width(HOLD_TICKS)`.
- Sub-module `debounce_channel` holds the per-lane synchroniser, history, hysteresis, edge and hold logic.
- The top level instantiates `debounce_channel` CHANNELS times in a generate loop and drives `load` and `rst` to every lane.

## Test plan
All cases use the defaults, except HOLD_TICKS=20 for the hold case.
- Reset, then `button`=5'b00000 and `load` every cycle for 50 cycles → all outputs 0, no pulses.
- `button[0]` steps 0→1 cleanly, `load` every cycle → `db[0]` rises on cycle 12 after the step. `rise[0]` is high for exactly that cycle. Other channels stay at 0.
- `button[1]` bounces 1,0,1,1,0 on consecutive ticks, then stays at 1 → `db[1]` rises only 10 ticks after the last 0. No `rise` during the bounce.
- `load` every 4 cycles, `button[2]` held high for 40 ticks, HOLD_TICKS=20 → `hold_pulse[2]` fires once, 20 ticks after `db[2]` rises. `hold[2]` stays high. The release 0→1→0 gives `fall[2]` and drops `hold[2]` in the same cycle.
- Assert `rst` while `db[3]`=1 and `cnt` is mid-count → all outputs are 0 immediately. With the button still pressed, `db[3]` requalifies after 2+10 cycles with a fresh `rise[3]`.
- All five channels toggle on different ticks → every channel's `rise` and `fall` count equals its number of stable transitions. `rise` and `fall` are never both high on one channel.

Source files
------------

// File: rtl/debounce_pkg.sv
// Shared defaults and helpers for the multi-channel debouncer.
// Imported by debounce_channel and debounce_multi.
package debounce_pkg;

    localparam int DEF_CHANNELS    = 5;
    localparam int DEF_DEPTH       = 10;
    localparam int DEF_SYNC_STAGES = 2;
    localparam int DEF_HOLD_TICKS  = 500;

    // Width of a counter that must reach hold_ticks inclusive.
    function automatic int cnt_width(input int hold_ticks);
        return $clog2(hold_ticks + 1);
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// One debouncer lane: synchroniser, sample history with hysteresis,
// registered edge pulses and a saturating long-press counter.
module debounce_channel
    import debounce_pkg::*;
#(
    parameter int DEPTH       = DEF_DEPTH,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int HOLD_TICKS  = DEF_HOLD_TICKS
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic button,
    output logic db,
    output logic rise,
    output logic fall,
    output logic hold,
    output logic hold_pulse
);

    localparam int             CW       = cnt_width(HOLD_TICKS);
    localparam logic [CW-1:0] HOLD_MAX = CW'(HOLD_TICKS);

    logic [SYNC_STAGES-1:0] sync;
    logic                   s;
    logic [DEPTH-1:0]       h;
    logic [DEPTH-1:0]       hn;
    logic                   qual_high;
    logic                   qual_low;
    logic                   db_next;
    logic [CW-1:0]          cnt;
    logic [CW-1:0]          cnt_next;

    assign s = sync[SYNC_STAGES-1];

    // NOTE: every signal written here gets a default first so no latch is inferred.
    always_comb begin
        hn        = {h[DEPTH-2:0], s};
        qual_high = load && (&hn);
        qual_low  = load && !(|hn);

        db_next = db;
        if (qual_high) begin
            db_next = 1'b1;
        end else if (qual_low) begin
            db_next = 1'b0;
        end

        // Clearing on db_next drops hold together with the fall pulse; gating
        // the increment on the old db keeps the qualifying tick out of the count.
        cnt_next = cnt;
        if (!db_next) begin
            cnt_next = '0;
        end else if (db && load && (cnt != HOLD_MAX)) begin
            cnt_next = cnt + CW'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync       <= '0;
            h          <= '0;
            db         <= 1'b0;
            rise       <= 1'b0;
            fall       <= 1'b0;
            cnt        <= '0;
            hold_pulse <= 1'b0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], button};
            if (load) begin
                h <= hn;
            end
            db         <= db_next;
            rise       <= db_next && !db;
            fall       <= !db_next && db;
            cnt        <= cnt_next;
            hold_pulse <= (cnt_next == HOLD_MAX) && (cnt != HOLD_MAX);
        end
    end

    assign hold = (cnt == HOLD_MAX);

endmodule

// File: rtl/debounce_multi.sv
// Multi-channel push-button/switch debouncer: CHANNELS independent lanes
// sharing one sample tick and one reset.
module debounce_multi
    import debounce_pkg::*;
#(
    parameter int CHANNELS    = DEF_CHANNELS,
    parameter int DEPTH       = DEF_DEPTH,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int HOLD_TICKS  = DEF_HOLD_TICKS
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                load,
    input  logic [CHANNELS-1:0] button,
    output logic [CHANNELS-1:0] db,
    output logic [CHANNELS-1:0] rise,
    output logic [CHANNELS-1:0] fall,
    output logic [CHANNELS-1:0] hold,
    output logic [CHANNELS-1:0] hold_pulse
);

    for (genvar i = 0; i < CHANNELS; i++) begin : g_lane
        debounce_channel #(
            .DEPTH       (DEPTH),
            .SYNC_STAGES (SYNC_STAGES),
            .HOLD_TICKS  (HOLD_TICKS)
        ) u_lane (
            .clk        (clk),
            .rst        (rst),
            .load       (load),
            .button     (button[i]),
            .db         (db[i]),
            .rise       (rise[i]),
            .fall       (fall[i]),
            .hold       (hold[i]),
            .hold_pulse (hold_pulse[i])
        );
    end

endmodule
